tlc_conflict_monitor: RTL and testbench
=======================================

# tlc_conflict_monitor

Independent safety monitor that sits on the lamp side of the traffic light controller and checks the four 3-bit road lamp codes it drives. It checks, every clock, for illegal lamp codes, conflicting right-of-way, illegal per-road lamp sequences and green/yellow dwell-time violations. It latches the first fault with a code and road mask, and produces a flash square wave for the downstream lamp driver to force flashing mode. The monitor is purely observational and never feeds back into the controller.

## Interface
- MAX_GREEN, default 20: maximum consecutive green samples per road without override; legal range 1..30.
- YELLOW_CYC, default 4: required consecutive yellow samples per road; legal range 1..30.
- FLASH_HALF, default 2: flash half-period in cycles; legal range 1..31.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- East_road, North_road, West_road, South_road  in  3 each  lamp codes: Red=100, Yellow=010, Green=001, RedYellow=110, none=000.
- override  in  1  high while the controller is serving Emergency or Jam (|Emergency | |Jam).
- fault_clr  in  1  synchronous clear of the latched fault.
- fault  out  1  latched fault flag.
- fault_code  out  3  0 none, 1 ILLEGAL_CODE, 2 CONFLICT, 3 BAD_TRANSITION, 4 SHORT_YELLOW, 5 GREEN_TIMEOUT, 6 YELLOW_TIMEOUT.
- fault_road  out  4  road mask: East 1000, North 0100, West 0010, South 0001.
- flash  out  1  toggles every FLASH_HALF cycles while fault=1; 0 otherwise.

## Operation
- Each road is sampled every posedge. Per road, the block holds the previous code and a 5-bit dwell counter that saturates at 31.
- **Dwell counter:**
  - Increments while the code is unchanged.
  - Set to 1 when the code changes.
  - Forced to 0 while override=1.
- **ILLEGAL_CODE:** any road shows 011, 101 or 111.
- **CONFLICT:** more than one road shows 001 or 010, or more than one road shows 110.
- **BAD_TRANSITION:**
  - Legal per-road transitions are hold, 100→110, 110→001, 001→010, 010→100, and 000→any.
  - Any other change is a violation.
  - Not checked on samples where override=1.
- **SHORT_YELLOW:** a road leaves 010 with dwell < YELLOW_CYC. Not checked when override=1.
- **GREEN_TIMEOUT:** a road's green dwell reaches MAX_GREEN+1.
- **YELLOW_TIMEOUT:** a road's yellow dwell reaches YELLOW_CYC+1.
- **Simultaneous violations:** the lowest nonzero code wins. fault_road is the OR of all roads involved in the winning code; for CONFLICT it marks all offending roads.
- **Latching:**
  - The first fault is latched and later violations do not overwrite it.
  - fault_clr=1 clears fault, fault_code, fault_road and flash.
  - A violation on the same edge as fault_clr is latched (clear then capture).
- **Flash generator:** flash counter runs only while fault=1 and restarts from 0 when a fault is latched.

## Timing
- Reset (rst low, asynchronous): fault=0, fault_code=0, fault_road=0000, flash=0, all previous codes=000, all dwell counters=0.
- Latency: a violation sampled at edge N gives registered outputs valid after edge N. No combinational path from inputs to outputs.
- After reset release, the first sample compares against previous code 000, so every transition is legal.
- Reset mid-fault clears the latched fault immediately.
- flash first rises on the edge after fault latches, then toggles every FLASH_HALF edges.
- Override entry and exit: the sample on which override falls is still exempt. Checks resume on the next sample, with dwell counters starting from 0.

## Structure
- Shared package tlc_pkg holds:
  - lamp encodings RED, YELLOW, GREEN, RED_YELLOW, NONE;
  - fault code constants;
  - one-hot road masks.
- One sub-module, tlc_road_tracker, is instantiated 4×. It contains the previous-code register, the dwell counter, and the per-road flags illegal, bad_transition, short_yellow, green_timeout and yellow_timeout.
- The top level holds the cross-road conflict check, priority encoder, latch and flash counter.

## Test plan
- Normal cycle, E/N/W/S each at 20 green + 4 yellow with no override → fault stays 0 for 200 cycles.
- North_road=101 for one cycle → fault=1, fault_code=1, fault_road=0100 after that edge; flash toggles every 2 cycles.
- East_road=001 and West_road=010 simultaneously → fault_code=2, fault_road=1010.
- South 001→100 with override=0 → fault_code=3, fault_road=0001. Same step with override=1 → no fault.
- East yellow held 2 cycles then 100 → fault_code=4. East green held 21 samples → fault_code=5, fault_road=1000. Assert fault_clr with a new illegal code on the same edge → fault_code=1.
- Reset asserted while fault=1 and flash toggling → all outputs 0 immediately. After release, 000→001 is accepted without fault.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared lamp encodings, fault codes and road masks for the traffic light
// controller and its lamp-side conflict monitor.
package tlc_pkg;

  typedef logic [2:0] lamp_t;

  localparam lamp_t RED        = 3'b100;
  localparam lamp_t YELLOW     = 3'b010;
  localparam lamp_t GREEN      = 3'b001;
  localparam lamp_t RED_YELLOW = 3'b110;
  localparam lamp_t NONE       = 3'b000;

  typedef enum logic [2:0] {
    FC_NONE           = 3'd0,
    FC_ILLEGAL_CODE   = 3'd1,
    FC_CONFLICT       = 3'd2,
    FC_BAD_TRANSITION = 3'd3,
    FC_SHORT_YELLOW   = 3'd4,
    FC_GREEN_TIMEOUT  = 3'd5,
    FC_YELLOW_TIMEOUT = 3'd6
  } fault_code_t;

  localparam int NUM_ROADS = 4;

  localparam logic [3:0] ROAD_EAST  = 4'b1000;
  localparam logic [3:0] ROAD_NORTH = 4'b0100;
  localparam logic [3:0] ROAD_WEST  = 4'b0010;
  localparam logic [3:0] ROAD_SOUTH = 4'b0001;

  // Index order used everywhere inside the monitor: 0 East .. 3 South.
  localparam logic [3:0] ROAD_MASK [NUM_ROADS] = '{ROAD_EAST, ROAD_NORTH, ROAD_WEST, ROAD_SOUTH};

  localparam int         DWELL_W   = 5;
  localparam logic [4:0] DWELL_MAX = 5'd31;

  typedef struct packed {
    logic illegal;
    logic bad_transition;
    logic short_yellow;
    logic green_timeout;
    logic yellow_timeout;
  } road_flags_t;

  function automatic logic is_illegal(input lamp_t code);
    return (code == 3'b011) || (code == 3'b101) || (code == 3'b111);
  endfunction

  // Dark lamps (power-up or after reset) may come up in any state.
  function automatic logic legal_step(input lamp_t prev, input lamp_t cur);
    return (cur == prev)
        || (prev == NONE)
        || (prev == RED        && cur == RED_YELLOW)
        || (prev == RED_YELLOW && cur == GREEN)
        || (prev == GREEN      && cur == YELLOW)
        || (prev == YELLOW     && cur == RED);
  endfunction

endpackage

// File: rtl/tlc_road_tracker.sv
// Per-road lamp history: previous code, saturating dwell counter and the
// single-road violation flags for the current sample.
module tlc_road_tracker
  import tlc_pkg::*;
#(
  parameter int MAX_GREEN  = 20,
  parameter int YELLOW_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  lamp_t       code,
  input  logic        exempt,
  output road_flags_t flags
);

  localparam logic [DWELL_W-1:0] YELLOW_MIN   = DWELL_W'(YELLOW_CYC);
  localparam logic [DWELL_W-1:0] GREEN_LIMIT  = DWELL_W'(MAX_GREEN + 1);
  localparam logic [DWELL_W-1:0] YELLOW_LIMIT = DWELL_W'(YELLOW_CYC + 1);

  lamp_t              prev_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_d;

  always_comb begin
    dwell_d = dwell_q;
    if (exempt) begin
      dwell_d = '0;
    end else if (code != prev_q) begin
      dwell_d = DWELL_W'(1);
    end else if (dwell_q != DWELL_MAX) begin
      dwell_d = dwell_q + DWELL_W'(1);
    end
  end

  // Timeouts look at the dwell including this sample, so the limit trips on
  // the sample that makes the count reach it.
  always_comb begin
    flags                = '0;
    flags.illegal        = is_illegal(code);
    flags.bad_transition = !exempt && !legal_step(prev_q, code);
    flags.short_yellow   = !exempt && (prev_q == YELLOW) && (code != YELLOW)
                           && (dwell_q < YELLOW_MIN);
    flags.green_timeout  = (code == GREEN)  && (dwell_d >= GREEN_LIMIT);
    flags.yellow_timeout = (code == YELLOW) && (dwell_d >= YELLOW_LIMIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= NONE;
      dwell_q <= '0;
    end else begin
      prev_q  <= code;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/tlc_conflict_monitor.sv
// Lamp-side safety monitor: cross-road conflict check, fault priority,
// first-fault latch and the flash square wave for the lamp driver.
module tlc_conflict_monitor
  import tlc_pkg::*;
#(
  parameter int MAX_GREEN  = 20,
  parameter int YELLOW_CYC = 4,
  parameter int FLASH_HALF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] East_road,
  input  logic [2:0] North_road,
  input  logic [2:0] West_road,
  input  logic [2:0] South_road,
  input  logic       override,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [3:0] fault_road,
  output logic       flash
);

  localparam logic [4:0] FLASH_LAST = 5'(FLASH_HALF - 1);

  lamp_t       codes [NUM_ROADS];
  road_flags_t flags [NUM_ROADS];

  logic        override_q;
  logic        exempt;
  logic [2:0]  n_gy, n_ry;
  logic [3:0]  gy_mask, ry_mask, conflict_mask;
  logic [3:0]  illegal_mask, bad_mask, short_mask, green_to_mask, yellow_to_mask;
  fault_code_t viol_code;
  logic [3:0]  viol_road;
  logic        capture;
  fault_code_t code_q;
  logic [4:0]  flash_cnt;

  assign codes[0] = East_road;
  assign codes[1] = North_road;
  assign codes[2] = West_road;
  assign codes[3] = South_road;

  // The sample on which override drops is still exempt, so sequence checks
  // restart cleanly with zeroed dwell counters one sample later.
  assign exempt = override | override_q;

  for (genvar i = 0; i < NUM_ROADS; i++) begin : g_road
    tlc_road_tracker #(
      .MAX_GREEN  (MAX_GREEN),
      .YELLOW_CYC (YELLOW_CYC)
    ) u_tracker (
      .clk    (clk),
      .rst    (rst),
      .code   (codes[i]),
      .exempt (exempt),
      .flags  (flags[i])
    );
  end

  always_comb begin
    n_gy           = '0;
    n_ry           = '0;
    gy_mask        = '0;
    ry_mask        = '0;
    illegal_mask   = '0;
    bad_mask       = '0;
    short_mask     = '0;
    green_to_mask  = '0;
    yellow_to_mask = '0;
    for (int i = 0; i < NUM_ROADS; i++) begin
      if (codes[i] == GREEN || codes[i] == YELLOW) begin
        n_gy    = n_gy + 3'd1;
        gy_mask = gy_mask | ROAD_MASK[i];
      end
      if (codes[i] == RED_YELLOW) begin
        n_ry    = n_ry + 3'd1;
        ry_mask = ry_mask | ROAD_MASK[i];
      end
      if (flags[i].illegal)        illegal_mask   = illegal_mask   | ROAD_MASK[i];
      if (flags[i].bad_transition) bad_mask       = bad_mask       | ROAD_MASK[i];
      if (flags[i].short_yellow)   short_mask     = short_mask     | ROAD_MASK[i];
      if (flags[i].green_timeout)  green_to_mask  = green_to_mask  | ROAD_MASK[i];
      if (flags[i].yellow_timeout) yellow_to_mask = yellow_to_mask | ROAD_MASK[i];
    end
    conflict_mask = ((n_gy > 3'd1) ? gy_mask : 4'b0000)
                  | ((n_ry > 3'd1) ? ry_mask : 4'b0000);
  end

  // Lowest fault code wins; the road mask covers every road showing it.
  always_comb begin
    viol_code = FC_NONE;
    viol_road = '0;
    if (|illegal_mask) begin
      viol_code = FC_ILLEGAL_CODE;
      viol_road = illegal_mask;
    end else if (|conflict_mask) begin
      viol_code = FC_CONFLICT;
      viol_road = conflict_mask;
    end else if (|bad_mask) begin
      viol_code = FC_BAD_TRANSITION;
      viol_road = bad_mask;
    end else if (|short_mask) begin
      viol_code = FC_SHORT_YELLOW;
      viol_road = short_mask;
    end else if (|green_to_mask) begin
      viol_code = FC_GREEN_TIMEOUT;
      viol_road = green_to_mask;
    end else if (|yellow_to_mask) begin
      viol_code = FC_YELLOW_TIMEOUT;
      viol_road = yellow_to_mask;
    end
  end

  assign capture    = (!fault || fault_clr) && (viol_code != FC_NONE);
  assign fault_code = code_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      override_q <= 1'b0;
      fault      <= 1'b0;
      code_q     <= FC_NONE;
      fault_road <= '0;
      flash      <= 1'b0;
      flash_cnt  <= '0;
    end else begin
      override_q <= override;
      if (capture) begin
        fault      <= 1'b1;
        code_q     <= viol_code;
        fault_road <= viol_road;
        flash      <= 1'b0;
        flash_cnt  <= '0;
      end else if (fault_clr) begin
        fault      <= 1'b0;
        code_q     <= FC_NONE;
        fault_road <= '0;
        flash      <= 1'b0;
        flash_cnt  <= '0;
      end else if (fault) begin
        // Toggle when the phase counter wraps to 0, starting one edge after capture.
        if (flash_cnt == 5'd0) flash <= ~flash;
        flash_cnt <= (flash_cnt == FLASH_LAST) ? 5'd0 : flash_cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Randomized and directed bench for tlc_conflict_monitor with a behavioural
// reference model and an expected-response queue drained by a monitor.
module tb_tlc_conflict_monitor;

  localparam int MAX_GREEN  = 20;
  localparam int YELLOW_CYC = 4;
  localparam int FLASH_HALF = 2;

  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] Y  = 3'b010;
  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] RY = 3'b110;
  localparam logic [2:0] N0 = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] road_in [4];
  logic       override  = 1'b0;
  logic       fault_clr = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic [3:0] fault_road;
  logic       flash;

  logic [8:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  string      phase  = "reset";

  // reference model state
  logic [2:0] m_prev [4];
  int         m_dwell [4];
  bit         m_ovr_d;
  bit         m_fault;
  logic [2:0] m_code;
  logic [3:0] m_road;
  int         m_k;

  tlc_conflict_monitor #(
    .MAX_GREEN  (MAX_GREEN),
    .YELLOW_CYC (YELLOW_CYC),
    .FLASH_HALF (FLASH_HALF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .East_road  (road_in[0]),
    .North_road (road_in[1]),
    .West_road  (road_in[2]),
    .South_road (road_in[3]),
    .override   (override),
    .fault_clr  (fault_clr),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_road (fault_road),
    .flash      (flash)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int r = 0; r < 4; r++) begin
      m_prev[r]  = 3'b000;
      m_dwell[r] = 0;
    end
    m_ovr_d = 0;
    m_fault = 0;
    m_code  = 3'd0;
    m_road  = 4'b0000;
    m_k     = 0;
  endtask

  function automatic bit step_ok(input logic [2:0] p, input logic [2:0] c);
    return (c == p) || (p == N0) || (p == R && c == RY) || (p == RY && c == G)
        || (p == G && c == Y) || (p == Y && c == R);
  endfunction

  // One sample of the rules applied to the inputs currently on the pins.
  task automatic model_step();
    bit         exempt;
    logic [3:0] vm [7];
    int         nd [4];
    int         n_gy, n_ry, win;
    logic [3:0] gy_m, ry_m;
    bit         fl;
    exempt = override || m_ovr_d;
    for (int f = 0; f < 7; f++) vm[f] = 4'b0000;
    n_gy = 0; n_ry = 0; gy_m = 4'b0000; ry_m = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      logic [2:0] c, p;
      logic [3:0] bitm;
      c = road_in[r];
      p = m_prev[r];
      bitm = 4'b1000 >> r;
      if (exempt) nd[r] = 0;
      else if (c != p) nd[r] = 1;
      else nd[r] = (m_dwell[r] + 1 > 31) ? 31 : m_dwell[r] + 1;
      if (c == 3'b011 || c == 3'b101 || c == 3'b111) vm[1] |= bitm;
      if (c == G || c == Y) begin n_gy++; gy_m |= bitm; end
      if (c == RY) begin n_ry++; ry_m |= bitm; end
      if (!exempt && !step_ok(p, c)) vm[3] |= bitm;
      if (!exempt && p == Y && c != Y && m_dwell[r] < YELLOW_CYC) vm[4] |= bitm;
      if (c == G && nd[r] >= MAX_GREEN + 1) vm[5] |= bitm;
      if (c == Y && nd[r] >= YELLOW_CYC + 1) vm[6] |= bitm;
    end
    if (n_gy > 1) vm[2] |= gy_m;
    if (n_ry > 1) vm[2] |= ry_m;
    win = 0;
    for (int f = 1; f < 7; f++) if (win == 0 && vm[f] != 4'b0000) win = f;
    if (fault_clr) begin
      m_fault = 0; m_code = 3'd0; m_road = 4'b0000;
    end
    if (!m_fault && win != 0) begin
      m_fault = 1; m_code = 3'(win); m_road = vm[win]; m_k = 0;
    end else if (m_fault) begin
      m_k++;
    end
    fl = m_fault && (m_k >= 1) && ((((m_k - 1) / FLASH_HALF) % 2) == 0);
    exp_q.push_back({m_fault, m_code, m_road, fl});
    for (int r = 0; r < 4; r++) begin
      m_prev[r]  = road_in[r];
      m_dwell[r] = nd[r];
    end
    m_ovr_d = override;
  endtask

  task automatic drive(input logic [2:0] e, input logic [2:0] n, input logic [2:0] w,
                       input logic [2:0] s, input bit ovr, input bit clr);
    @(negedge clk);
    road_in[0] = e; road_in[1] = n; road_in[2] = w; road_in[3] = s;
    override = ovr; fault_clr = clr;
    model_step();
  endtask

  task automatic clear_all();
    drive(R, R, R, R, 1, 1);
    drive(R, R, R, R, 0, 1);
    drive(R, R, R, R, 0, 0);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({fault, fault_code, fault_road, flash} !== 9'd0) begin
      errors++;
      $display("FAIL %s: got fault=%b code=%0d road=%b flash=%b, want all zero",
               name, fault, fault_code, fault_road, flash);
    end
  endtask

  // monitor: compares every registered output sample against the model
  initial begin
    logic [8:0] exp, got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {fault, fault_code, fault_road, flash};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL out[%s] cyc=%0d got f=%b c=%0d r=%b fl=%b want f=%b c=%0d r=%b fl=%b",
                   phase, cyc, got[8], got[7:5], got[4:1], got[0],
                   exp[8], exp[7:5], exp[4:1], exp[0]);
        end
      end
    end
  end

  initial begin
    logic [2:0] cur [4];
    bit         ovr;
    for (int r = 0; r < 4; r++) road_in[r] = N0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_zero("reset");

    @(negedge clk);
    rst = 1'b1;
    model_step();

    phase = "normal";
    for (int round = 0; round < 2; round++) begin
      for (int r = 0; r < 4; r++) begin
        for (int q = 0; q < 4; q++) cur[q] = R;
        cur[r] = RY;
        drive(cur[0], cur[1], cur[2], cur[3], 0, 0);
        cur[r] = G;
        repeat (MAX_GREEN) drive(cur[0], cur[1], cur[2], cur[3], 0, 0);
        cur[r] = Y;
        repeat (YELLOW_CYC) drive(cur[0], cur[1], cur[2], cur[3], 0, 0);
      end
    end
    drive(R, R, R, R, 0, 0);

    phase = "illegal";
    drive(R, 3'b101, R, R, 0, 0);
    repeat (8) drive(R, R, R, R, 0, 0);
    clear_all();

    phase = "conflict";
    drive(G, R, Y, R, 0, 0);
    drive(R, R, R, R, 0, 0);
    clear_all();

    phase = "bad_trans";
    drive(R, R, R, RY, 0, 0);
    drive(R, R, R, G, 0, 0);
    drive(R, R, R, R, 0, 0);
    clear_all();

    phase = "override";
    drive(R, R, R, RY, 0, 0);
    drive(R, R, R, G, 0, 0);
    drive(R, R, R, R, 1, 0);
    drive(R, R, R, R, 0, 0);
    repeat (3) drive(R, R, R, R, 0, 0);

    phase = "short_yellow";
    drive(RY, R, R, R, 0, 0);
    drive(G, R, R, R, 0, 0);
    drive(Y, R, R, R, 0, 0);
    drive(Y, R, R, R, 0, 0);
    drive(R, R, R, R, 0, 0);
    clear_all();

    phase = "green_timeout";
    drive(RY, R, R, R, 0, 0);
    repeat (MAX_GREEN + 1) drive(G, R, R, R, 0, 0);
    drive(G, R, R, R, 0, 0);

    phase = "clr_capture";
    drive(G, 3'b101, R, R, 0, 1);
    repeat (5) drive(G, R, R, R, 0, 0);

    phase = "async_reset";
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero("async_reset");
    for (int r = 0; r < 4; r++) road_in[r] = N0;
    override = 1'b0; fault_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset_hold");
    rst = 1'b1;
    model_step();

    phase = "power_up";
    repeat (5) drive(G, N0, N0, N0, 0, 0);
    repeat (YELLOW_CYC) drive(Y, R, R, R, 0, 0);
    drive(R, R, R, R, 0, 0);
    clear_all();

    phase = "random";
    for (int q = 0; q < 4; q++) cur[q] = R;
    ovr = 0;
    for (int i = 0; i < 1500; i++) begin
      bit clr;
      for (int r = 0; r < 4; r++) begin
        int pick;
        pick = $urandom_range(0, 99);
        if (pick == 99) cur[r] = 3'($urandom_range(0, 7));
        else if (pick < 6) begin
          case (cur[r])
            R:       cur[r] = RY;
            RY:      cur[r] = G;
            G:       cur[r] = Y;
            default: cur[r] = R;
          endcase
        end
      end
      if ($urandom_range(0, 19) == 0) ovr = !ovr;
      clr = ($urandom_range(0, 14) == 0);
      drive(cur[0], cur[1], cur[2], cur[3], ovr, clr);
    end

    phase = "drain";
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
